adder_seq: RTL and testbench
============================

# adder_seq

Multi-precision add/subtract sequencer that shares one WIDTH-bit limb adder across a LIMBS*WIDTH-bit operation. It accepts one wide request via valid/ready, walks the limbs LSB-first through a single adder instance at one limb per cycle while rippling the carry in a register, and returns the full result via valid/ready. It sits between an operand source (register file or DMA staging) and result writeback wherever wide integer add is needed without a full-width carry chain.

## Interface
- WIDTH, 128: limb width in bits, ≥1
- LIMBS, 4: number of limbs per operation, ≥1
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_a  in  LIMBS*WIDTH  operand A
- in_b  in  LIMBS*WIDTH  operand B
- in_cin  in  1  carry-in (add) / borrow-in (sub)
- in_sub  in  1  0: A+B+cin; 1: A−B−cin
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_sum  out  LIMBS*WIDTH  result, modulo 2^(LIMBS*WIDTH)
- out_cout  out  1  final carry; for sub, 1 = no borrow
- busy  out  1  state != IDLE
- out_ovf  out  1  signed overflow (only with ADDER_SEQ_OVF_EN)

## Operation
- States: IDLE, RUN, DONE. in_ready = (state==IDLE), combinational from state.
- IDLE: on input handshake, latch A, B' = in_sub ? ~in_b : in_b, carry = in_sub ? ~in_cin : in_cin; clear limb index k; clear out_sum; go RUN.
- RUN: each cycle, limb k: {c, s} = A[k] + B'[k] + carry; write s to out_sum[k], carry ← c; k ← k+1. After k==LIMBS−1, go DONE and register out_cout = final carry.
- DONE: out_valid=1; out_sum/out_cout/out_ovf held stable until out_ready; on handshake go IDLE.
- in_valid is ignored outside IDLE; in_a/in_b need only be stable in the handshake cycle.
- Subtraction is two's-complement: A + ~B + ~borrow_in.
- LIMBS=1: RUN lasts exactly one cycle; k never wraps past LIMBS−1 (index counter width clog2(LIMBS), min 1).

## Timing
- Reset (reset_n low, any state incl. RUN/DONE): state IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, busy=0, carry=0, k=0; in-flight op discarded, no output produced.
- Accept in cycle 0 → RUN in cycles 1..LIMBS → out_valid first high in cycle LIMBS+1 (latency LIMBS+1).
- out_ready held high: out handshake in cycle LIMBS+1, in_ready high in cycle LIMBS+2; sustained throughput one op per LIMBS+2 cycles.
- out_ready low: DONE held indefinitely, outputs unchanged, in_ready stays 0.
- No simultaneous in/out handshake (in_ready and out_valid never both high).

## Configuration
- ADDER_SEQ_OVF_EN defined: out_ovf port and logic present; computed on the final limb as (A_msb == B'_msb) && (s_msb != A_msb), registered with out_cout, held through DONE, cleared on reset.
- Undefined: out_ovf port and its logic absent; all other behaviour identical.

## Structure
- Package adder_seq_pkg: state enum typedef (ST_IDLE, ST_RUN, ST_DONE); limb-index width helper function.
- Sub-module adder_limb: combinational WIDTH-bit a+b+cin → {cout, sum}, single instance driven by limb muxes on A/B' indexed by k.

## Test plan
- Reset: hold reset_n low 3 cycles, release → in_ready=1, out_valid=0, busy=0, out_sum=0, out_cout=0.
- Full ripple (WIDTH=128, LIMBS=4): A=2^512−1, B=1, cin=0, add → out_sum=0, out_cout=1, out_valid in cycle 5 after accept.
- Subtract with borrow: A=5, B=7, cin=0, sub → out_sum=2^512−2, out_cout=0, out_ovf=0; A=7, B=5, cin=1 → out_sum=1, out_cout=1.
- Backpressure: out_ready low 10 cycles after out_valid, in_valid high with new operands → out_sum/out_cout stable, in_ready=0, new request accepted only after out handshake.
- Reset mid-op: accept A=1, B=1, pulse reset_n low in cycle 2 → outputs to reset values, no out_valid; next op A=3, B=4 → out_sum=7.
- Overflow (OVF_EN): A=2^511−1, B=1, add → out_sum=2^511, out_ovf=1, out_cout=0; LIMBS=1 build: A=1, B=2 → out_sum=3, out_valid in cycle 2.

Source files
------------

// File: rtl/adder_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_seq_pkg
// Description : Shared types and helpers for the adder_seq limb sequencer.
//               - state_t     : sequencer state encoding
//               - idx_width() : width of the limb index counter (minimum 1)
// Revision    : 1.0 - initial release
// ============================================================================
package adder_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A single-limb configuration still needs a 1-bit counter so the index
    // signal has a legal, non-zero width.
    function automatic int idx_width(input int limbs);
        return (limbs <= 1) ? 1 : $clog2(limbs);
    endfunction

endpackage : adder_seq_pkg
`default_nettype wire

// File: rtl/adder_limb.sv
`default_nettype none
// ============================================================================
// Module      : adder_limb
// Description : Combinational WIDTH-bit adder, {cout, sum} = a + b + cin.
//               Shared by every limb of a wide operation.
// Ports       : a, b    [WIDTH-1:0] in   limb operands
//               cin              in      carry into bit 0
//               sum     [WIDTH-1:0] out  limb result
//               cout             out     carry out of the MSB
// Revision    : 1.0 - initial release
// ============================================================================
module adder_limb #(
    parameter int WIDTH = 128
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule : adder_limb
`default_nettype wire

// File: rtl/adder_seq.sv
`default_nettype none
// ============================================================================
// Module      : adder_seq
// Description : Multi-precision add/subtract sequencer. One wide request is
//               accepted, its limbs are processed LSB-first through a single
//               WIDTH-bit adder (one limb per cycle, carry kept in a
//               register), and the full result is returned on a valid/ready
//               output.
// Ports       : clock, reset_n            clock / async active-low reset
//               in_valid, in_ready        request handshake
//               in_a, in_b [LIMBS*WIDTH]  operands
//               in_cin, in_sub            carry/borrow in, 1 = subtract
//               out_valid, out_ready      result handshake
//               out_sum [LIMBS*WIDTH]     result modulo 2^(LIMBS*WIDTH)
//               out_cout                  final carry (sub: 1 = no borrow)
//               busy                      sequencer not idle
//               out_ovf                   signed overflow (ADDER_SEQ_OVF_EN)
// Config      : `define ADDER_SEQ_OVF_EN to add the out_ovf port and logic.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_seq
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int LIMBS = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LIMBS*WIDTH-1:0] in_a,
    input  logic [LIMBS*WIDTH-1:0] in_b,
    input  logic                   in_cin,
    input  logic                   in_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LIMBS*WIDTH-1:0] out_sum,
    output logic                   out_cout,
    output logic                   busy
`ifdef ADDER_SEQ_OVF_EN
    ,
    output logic                   out_ovf
`endif
);

    localparam int             TOTAL  = LIMBS * WIDTH;
    localparam int             KW     = idx_width(LIMBS);
    localparam logic [KW-1:0]  K_LAST = KW'(LIMBS - 1);

    state_t            state;
    state_t            state_next;
    logic [TOTAL-1:0]  a_reg;
    logic [TOTAL-1:0]  b_reg;        // already inverted for subtraction
    logic              carry;
    logic [KW-1:0]     k;
    logic [31:0]       base;
    logic              in_fire;
    logic              last_limb;
    logic [WIDTH-1:0]  limb_a;
    logic [WIDTH-1:0]  limb_b;
    logic [WIDTH-1:0]  limb_sum;
    logic              limb_cout;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign in_fire   = in_valid && in_ready;
    assign last_limb = (k == K_LAST);

    // Bit offset of the current limb inside the wide operands.
    assign base   = 32'(k) * WIDTH;
    assign limb_a = a_reg[base +: WIDTH];
    assign limb_b = b_reg[base +: WIDTH];

    adder_limb #(
        .WIDTH (WIDTH)
    ) u_limb (
        .a    (limb_a),
        .b    (limb_b),
        .cin  (carry),
        .sum  (limb_sum),
        .cout (limb_cout)
    );

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (in_valid)  state_next = ST_RUN;
            ST_RUN:  if (last_limb) state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // Subtraction is folded into the operands at accept time:
    // A - B - borrow = A + ~B + ~borrow, so RUN is always a plain add.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= 1'b0;
            k        <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else begin
            if (in_fire) begin
                a_reg   <= in_a;
                b_reg   <= in_sub ? ~in_b : in_b;
                carry   <= in_sub ? ~in_cin : in_cin;
                k       <= '0;
                out_sum <= '0;
            end else if (state == ST_RUN) begin
                out_sum[base +: WIDTH] <= limb_sum;
                carry                  <= limb_cout;
                if (last_limb) begin
                    out_cout <= limb_cout;
                end else begin
                    k <= k + 1'b1;
                end
            end
        end
    end

`ifdef ADDER_SEQ_OVF_EN
    // On the last limb the limb MSBs are the sign bits of the wide operands.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_ovf <= 1'b0;
        end else if ((state == ST_RUN) && last_limb) begin
            out_ovf <= (limb_a[WIDTH-1] == limb_b[WIDTH-1]) &&
                       (limb_sum[WIDTH-1] != limb_a[WIDTH-1]);
        end
    end
`endif

endmodule : adder_seq
`default_nettype wire

// File: tb/tb_adder_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_seq
// Description : Self-checking bench for adder_seq. Expected results come from
//               a wide-integer reference model, are queued when a request is
//               accepted and compared when the DUT presents its result.
//               A second instance covers the single-limb configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_seq;

    localparam int W   = 128;
    localparam int L   = 4;
    localparam int TOT = W * L;
    localparam int SW  = 16;

    typedef struct packed {
        logic [TOT-1:0] sum;
        logic           cout;
        logic           ovf;
    } exp_t;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [TOT-1:0] in_a = '0;
    logic [TOT-1:0] in_b = '0;
    logic           in_cin = 1'b0;
    logic           in_sub = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [TOT-1:0] out_sum;
    logic           out_cout;
    logic           busy;

    logic           s_in_valid = 1'b0;
    logic           s_in_ready;
    logic [SW-1:0]  s_in_a = '0;
    logic [SW-1:0]  s_in_b = '0;
    logic           s_out_valid;
    logic           s_out_ready = 1'b0;
    logic [SW-1:0]  s_out_sum;
    logic           s_out_cout;
    logic           s_busy;
`ifdef ADDER_SEQ_OVF_EN
    logic           out_ovf;
    logic           s_out_ovf;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clock = ~clock;

    adder_seq #(.WIDTH(W), .LIMBS(L)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
`ifdef ADDER_SEQ_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    adder_seq #(.WIDTH(SW), .LIMBS(1)) dut_single (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_a      (s_in_a),
        .in_b      (s_in_b),
        .in_cin    (1'b0),
        .in_sub    (1'b0),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_sum   (s_out_sum),
        .out_cout  (s_out_cout),
        .busy      (s_busy)
`ifdef ADDER_SEQ_OVF_EN
        ,
        .out_ovf   (s_out_ovf)
`endif
    );

    function automatic exp_t model(input logic [TOT-1:0] a, input logic [TOT-1:0] b,
                                   input logic cin, input logic sub);
        exp_t           e;
        logic [TOT-1:0] bp;
        logic           c;
        logic [TOT:0]   r;
        bp     = sub ? ~b : b;
        c      = sub ? ~cin : cin;
        r      = {1'b0, a} + {1'b0, bp} + {{TOT{1'b0}}, c};
        e.sum  = r[TOT-1:0];
        e.cout = r[TOT];
        e.ovf  = (a[TOT-1] == bp[TOT-1]) && (r[TOT-1] != a[TOT-1]);
        return e;
    endfunction

    function automatic logic [TOT-1:0] rnd_wide();
        logic [TOT-1:0] v;
        for (int i = 0; i < TOT / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic send(input logic [TOT-1:0] a, input logic [TOT-1:0] b,
                        input logic cin, input logic sub);
        int t;
        t = 0;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(posedge clock); #1; t++;
        end
        if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: in_ready=%0b, required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        sb.push_back(model(a, b, cin, sub));
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic receive(input string name, input bit chk_lat);
        int   n;
        exp_t e;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clock); #1; n++;
        end
        n_cmp++;
        if (!out_valid) begin
            n_err++;
            $display("FAIL %s out_valid_timeout: got 0, required 1", name);
            return;
        end
        if (chk_lat) begin
            n_cmp++;
            if (n !== L) begin
                n_err++;
                $display("FAIL %s latency: got %0d, required %0d", name, n, L);
            end
        end
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s scoreboard_empty: got result, required none", name);
            return;
        end
        e = sb.pop_front();
        if (out_sum !== e.sum) begin
            n_err++;
            $display("FAIL %s out_sum: got %h, required %h", name, out_sum, e.sum);
        end
        n_cmp++;
        if (out_cout !== e.cout) begin
            n_err++;
            $display("FAIL %s out_cout: got %0b, required %0b", name, out_cout, e.cout);
        end
`ifdef ADDER_SEQ_OVF_EN
        n_cmp++;
        if (out_ovf !== e.ovf) begin
            n_err++;
            $display("FAIL %s out_ovf: got %0b, required %0b", name, out_ovf, e.ovf);
        end
`endif
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL %s in_ready_in_done: got %0b, required 0", name, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s after_handshake: got valid=%0b ready=%0b, required valid=0 ready=1",
                     name, out_valid, in_ready);
        end
    endtask

    task automatic check_reset_values(input string name);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s ctrl: got ready=%0b valid=%0b busy=%0b, required 1/0/0",
                     name, in_ready, out_valid, busy);
        end
        n_cmp++;
        if (out_sum !== '0 || out_cout !== 1'b0) begin
            n_err++;
            $display("FAIL %s data: got sum=%h cout=%0b, required 0/0", name, out_sum, out_cout);
        end
`ifdef ADDER_SEQ_OVF_EN
        n_cmp++;
        if (out_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL %s ovf: got %0b, required 0", name, out_ovf);
        end
`endif
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_values("reset_held");
        reset_n = 1'b1;
        @(posedge clock); #1;
        check_reset_values("reset_released");
    endtask

    task automatic test_full_ripple();
        send({TOT{1'b1}}, TOT'(1), 1'b0, 1'b0);
        n_cmp++;
        if (sb[0].sum !== '0 || sb[0].cout !== 1'b1) begin
            n_err++;
            $display("FAIL ripple_model: got sum=%h cout=%0b, required 0/1", sb[0].sum, sb[0].cout);
        end
        receive("full_ripple", 1'b1);
    endtask

    task automatic test_subtract();
        send(TOT'(5), TOT'(7), 1'b0, 1'b1);
        receive("sub_5_7", 1'b1);
        send(TOT'(7), TOT'(5), 1'b1, 1'b1);
        receive("sub_7_5_b1", 1'b1);
        for (int i = 0; i < 4; i++) begin
            send(rnd_wide(), rnd_wide(), 1'($urandom), 1'($urandom));
            receive("random_op", 1'b1);
        end
    endtask

    task automatic test_backpressure();
        logic [TOT-1:0] hold_sum;
        logic           hold_cout;
        send(rnd_wide(), rnd_wide(), 1'b0, 1'b0);
        for (int t = 0; t < 200 && !out_valid; t++) begin
            @(posedge clock); #1;
        end
        hold_sum  = out_sum;
        hold_cout = out_cout;
        in_a = TOT'(100); in_b = TOT'(23); in_cin = 1'b0; in_sub = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_sum !== hold_sum || out_cout !== hold_cout) begin
                n_err++;
                $display("FAIL backpressure_hold: got valid=%0b ready=%0b cout=%0b, required 1/0/%0b",
                         out_valid, in_ready, out_cout, hold_cout);
            end
        end
        receive("backpressure_first", 1'b0);
        send(TOT'(100), TOT'(23), 1'b0, 1'b0);
        receive("backpressure_second", 1'b1);
    endtask

    task automatic test_reset_mid_op();
        send(TOT'(1), TOT'(1), 1'b0, 1'b0);
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        check_reset_values("reset_mid_op");
        void'(sb.pop_back());
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 2 * L; i++) begin
            @(posedge clock); #1;
            n_cmp++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_discard: got valid=%0b busy=%0b, required 0/0", out_valid, busy);
            end
        end
        send(TOT'(3), TOT'(4), 1'b0, 1'b0);
        receive("after_reset_3_4", 1'b1);
    endtask

    task automatic test_back_to_back();
        int n;
        exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a = rnd_wide(); in_b = rnd_wide(); in_cin = 1'($urandom); in_sub = 1'(i & 1);
            in_valid = 1'b1;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_ready: got %0b, required 1", in_ready);
            end
            sb.push_back(model(in_a, in_b, in_cin, in_sub));
            @(posedge clock); #1;
            in_a = rnd_wide(); in_b = rnd_wide();
            n = 0;
            while (!in_ready && n < 200) begin
                if (out_valid) begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (out_sum !== e.sum || out_cout !== e.cout) begin
                        n_err++;
                        $display("FAIL b2b_result: got cout=%0b sum=%h, required cout=%0b sum=%h",
                                 out_cout, out_sum, e.cout, e.sum);
                    end
                end
                @(posedge clock); #1; n++;
            end
            n_cmp++;
            if (n !== L + 1) begin
                n_err++;
                $display("FAIL b2b_period: got %0d, required %0d", n, L + 1);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL b2b_drain: got %0d pending, required 0", sb.size());
        end
    endtask

`ifdef ADDER_SEQ_OVF_EN
    task automatic test_overflow();
        send({1'b0, {(TOT-1){1'b1}}}, TOT'(1), 1'b0, 1'b0);
        n_cmp++;
        if (sb[0].sum !== {1'b1, {(TOT-1){1'b0}}} || sb[0].ovf !== 1'b1 || sb[0].cout !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_model: got ovf=%0b cout=%0b, required 1/0", sb[0].ovf, sb[0].cout);
        end
        receive("overflow", 1'b1);
    endtask
`endif

    task automatic single_op(input logic [SW-1:0] a, input logic [SW-1:0] b,
                             input logic [SW-1:0] exp_sum, input logic exp_cout);
        int n;
        s_in_a = a; s_in_b = b; s_in_valid = 1'b1;
        n_cmp++;
        if (s_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_ready: got %0b, required 1", s_in_ready);
        end
        @(posedge clock); #1;
        s_in_valid = 1'b0;
        n = 0;
        while (!s_out_valid && n < 50) begin
            @(posedge clock); #1; n++;
        end
        n_cmp++;
        if (n !== 1) begin
            n_err++;
            $display("FAIL single_latency: got %0d, required 1", n);
        end
        n_cmp++;
        if (s_out_sum !== exp_sum || s_out_cout !== exp_cout) begin
            n_err++;
            $display("FAIL single_result: got sum=%h cout=%0b, required sum=%h cout=%0b",
                     s_out_sum, s_out_cout, exp_sum, exp_cout);
        end
        s_out_ready = 1'b1;
        @(posedge clock); #1;
        s_out_ready = 1'b0;
    endtask

    task automatic test_single_limb();
        single_op(16'd1, 16'd2, 16'd3, 1'b0);
        single_op(16'hFFFF, 16'h0001, 16'h0000, 1'b1);
    endtask

    initial begin
        test_reset();
        test_full_ripple();
        test_subtract();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
`ifdef ADDER_SEQ_OVF_EN
        test_overflow();
`endif
        test_single_limb();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_adder_seq
`default_nettype wire
